// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO responder: region codes, IO offsets,
// FSM encoding and the address decode helpers.
package mio_pkg;

    localparam logic [3:0]  REG_RAM  = 4'h0;
    localparam logic [3:0]  REG_SW   = 4'hE;
    localparam logic [3:0]  REG_IO   = 4'hF;

    localparam logic [27:0] OFF_LED  = 28'h0;
    localparam logic [27:0] OFF_CNT  = 28'h4;
    localparam logic [27:0] OFF_CTRL = 28'h8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_SW,
        SEL_IO,
        SEL_NONE
    } sel_t;

    // Regions 0x0-0x7 all map to RAM, so only the top bit is significant there.
    function automatic sel_t decode_region(input logic [3:0] region);
        if (region[3] == REG_RAM[3]) return SEL_RAM;
        if (region == REG_SW)        return SEL_SW;
        if (region == REG_IO)        return SEL_IO;
        return SEL_NONE;
    endfunction

    function automatic logic off_match(input logic [25:0] word_off, input logic [27:0] off);
        return word_off == off[27:2];
    endfunction

endpackage

// File: rtl/mio_timer.sv
// Down-counter peripheral with enable and a sticky zero-reached flag.
// Latency: register writes take effect on the strobe edge; no backpressure.
// Count saturates at zero; a load beats a decrement, an irq set beats a clear.
module mio_timer
    import mio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_vld,
    input  logic [31:0] load_dat,
    input  logic        ctrl_vld,
    input  logic [1:0]  ctrl_dat,
    output logic [31:0] count,
    output logic        cnt_en,
    output logic        cnt_irq
);

    logic [31:0] count_q, count_d;
    logic        en_q, en_d;
    logic        irq_q, irq_d;

    always_comb begin
        count_d = count_q;
        en_d    = en_q;
        irq_d   = irq_q;
        if (ctrl_vld) begin
            en_d = ctrl_dat[0];
            if (ctrl_dat[1]) irq_d = 1'b0;
        end
        if (load_vld) begin
            count_d = load_dat;
        end else if (en_q && count_q != 32'd0) begin
            count_d = count_q - 32'd1;
            if (count_q == 32'd1) irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 32'd0;
            en_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            en_q    <= en_d;
            irq_q   <= irq_d;
        end
    end

    assign count   = count_q;
    assign cnt_en  = en_q;
    assign cnt_irq = irq_q;

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO responder: decodes CPU requests to RAM, switches, LED and timer.
// Latency: peripheral ready one edge after sampling, RAM ready RAM_WAIT+1 edges after.
// Request is level-held by the CPU until mio_ready; inputs are ignored outside IDLE.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int RAM_AW   = 10,
    parameter int RAM_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       data_from_cpu,
    output logic [31:0]       data_to_cpu,
    output logic              mio_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              cnt_irq
);

    localparam logic [3:0] WCNT_INIT = 4'(RAM_WAIT - 1);

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    sel_t              sel_q, sel_d;
    logic [25:0]       off_q, off_d;
    logic              dir_q, dir_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [31:0]       rdat_q, rdat_d;
    logic [15:0]       led_q, led_d;

    sel_t        sel_in;
    logic [31:0] rd_mux;
    logic        io_wr;
    logic [31:0] t_count;
    logic        t_en;
    logic        t_irq;
    logic        unused_addr;

    assign unused_addr = ^addr_bus[1:0];
    assign sel_in      = decode_region(addr_bus[31:28]);

    // Peripheral read data is taken at the sampling edge, so it is ready in DONE.
    always_comb begin
        rd_mux = 32'd0;
        case (sel_in)
            SEL_SW: rd_mux = {16'd0, sw_in};
            SEL_IO: begin
                if (off_match(addr_bus[27:2], OFF_LED))       rd_mux = {16'd0, led_q};
                else if (off_match(addr_bus[27:2], OFF_CNT))  rd_mux = t_count;
                else if (off_match(addr_bus[27:2], OFF_CTRL)) rd_mux = {30'd0, t_irq, t_en};
            end
            default: rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        sel_d      = sel_q;
        off_d      = off_q;
        dir_d      = dir_q;
        ram_addr_d = ram_addr_q;
        wdat_d     = wdat_q;
        rdat_d     = rdat_q;
        led_d      = led_q;
        case (state_q)
            IDLE: begin
                if (mem_r || mem_w) begin
                    sel_d  = sel_in;
                    off_d  = addr_bus[27:2];
                    dir_d  = mem_w;
                    wdat_d = data_from_cpu;
                    if (sel_in == SEL_RAM) begin
                        ram_addr_d = addr_bus[RAM_AW+1:2];
                        wcnt_d     = WCNT_INIT;
                        state_d    = WAIT;
                    end else begin
                        if (!mem_w) rdat_d = rd_mux;
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == 4'd0) begin
                    if (!dir_q) rdat_d = ram_dout;
                    state_d = DONE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            DONE: begin
                if (io_wr && off_match(off_q, OFF_LED)) led_d = wdat_q[15:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wcnt_q     <= 4'd0;
            sel_q      <= SEL_NONE;
            off_q      <= 26'd0;
            dir_q      <= 1'b0;
            ram_addr_q <= '0;
            wdat_q     <= 32'd0;
            rdat_q     <= 32'd0;
            led_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            sel_q      <= sel_d;
            off_q      <= off_d;
            dir_q      <= dir_d;
            ram_addr_q <= ram_addr_d;
            wdat_q     <= wdat_d;
            rdat_q     <= rdat_d;
            led_q      <= led_d;
        end
    end

    assign io_wr = (state_q == DONE) && dir_q && (sel_q == SEL_IO);

    mio_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_vld (io_wr && off_match(off_q, OFF_CNT)),
        .load_dat (wdat_q),
        .ctrl_vld (io_wr && off_match(off_q, OFF_CTRL)),
        .ctrl_dat (wdat_q[1:0]),
        .count    (t_count),
        .cnt_en   (t_en),
        .cnt_irq  (t_irq)
    );

    // The wait counter starts at its init value, so that value marks the first WAIT cycle.
    assign ram_we      = (state_q == WAIT) && dir_q && (wcnt_q == WCNT_INIT);
    assign mio_ready   = (state_q == DONE);
    assign ram_addr    = ram_addr_q;
    assign ram_din     = wdat_q;
    assign data_to_cpu = rdat_q;
    assign led_out     = led_q;
    assign cnt_irq     = t_irq;

endmodule
